macguffin_arbiter: RTL and testbench

- Two-requester scheduler that shares one MacGuffin encryption core between two independent AXI4-Stream plaintext channels.
- Arbitrates input blocks round-robin and records the source channel of every accepted block in an in-order tag FIFO.
- Steers each ciphertext block from the core back to the channel that issued it.
- Sits between the requester clients and the MacGuffin top-level stream ports. Key setup and key_ready gating remain inside the core.

---
 rtl/macguffin_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_macguffin_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/macguffin_arbiter.sv
// macguffin_arbiter: round-robin scheduler sharing one MacGuffin core between
// two AXI4-Stream plaintext channels. Every accepted block's source channel is
// queued in an in-order tag FIFO so ciphertext is steered back to its issuer.
// DATA_W is the cipher block width; TAG_DEPTH bounds blocks in flight (power of two, >= 2).
// Optional build macro MACGUFFIN_ARB_LOCK_EN adds s*_axis_tlast and holds the
// grant on one channel until its tlast beat has been accepted.
module macguffin_arbiter #(
  parameter int DATA_W    = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            s0_axis_tdata,
  input  logic                         s0_axis_tvalid,
  output logic                         s0_axis_tready,
  input  logic [DATA_W-1:0]            s1_axis_tdata,
  input  logic                         s1_axis_tvalid,
  output logic                         s1_axis_tready,
`ifdef MACGUFFIN_ARB_LOCK_EN
  input  logic                         s0_axis_tlast,
  input  logic                         s1_axis_tlast,
`endif
  output logic [DATA_W-1:0]            m0_axis_tdata,
  output logic                         m0_axis_tvalid,
  input  logic                         m0_axis_tready,
  output logic [DATA_W-1:0]            m1_axis_tdata,
  output logic                         m1_axis_tvalid,
  input  logic                         m1_axis_tready,
  output logic [DATA_W-1:0]            core_s_axis_tdata,
  output logic                         core_s_axis_tvalid,
  input  logic                         core_s_axis_tready,
  input  logic [DATA_W-1:0]            core_m_axis_tdata,
  input  logic                         core_m_axis_tvalid,
  output logic                         core_m_axis_tready,
  output logic [$clog2(TAG_DEPTH):0]   in_flight,
  output logic                         err_orphan
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              state_p0;
  logic                gnt_p0;
  logic                last_p0;
  logic                vld_p0;
  logic [DATA_W-1:0]   data_p0;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic                full;
  logic                empty;
  logic                req0;
  logic                req1;
  logic                grant_now;
  logic                gnt_sel;
  logic                push;
  logic                pop;
  logic                head;

`ifdef MACGUFFIN_ARB_LOCK_EN
  logic                lock_p0;
  logic                lock_ch_p0;
  logic                sel_last;
`endif

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Requests eligible for a grant; a held lock masks out the other channel.
  always_comb begin
    req0 = s0_axis_tvalid;
    req1 = s1_axis_tvalid;
`ifdef MACGUFFIN_ARB_LOCK_EN
    if (lock_p0) begin
      req0 = s0_axis_tvalid & ~lock_ch_p0;
      req1 = s1_axis_tvalid &  lock_ch_p0;
    end
`endif
  end

  // Grant is taken only from IDLE with FIFO room; rst gating keeps readies low in reset.
  assign grant_now = rst && (state_p0 == IDLE) && !full && (req0 || req1);
  assign gnt_sel   = (req0 && req1) ? ~last_p0 : req1;

  assign s0_axis_tready = grant_now && !gnt_sel;
  assign s1_axis_tready = grant_now &&  gnt_sel;

`ifdef MACGUFFIN_ARB_LOCK_EN
  assign sel_last = gnt_sel ? s1_axis_tlast : s0_axis_tlast;
`endif

  assign core_s_axis_tvalid = vld_p0;
  assign core_s_axis_tdata  = data_p0;

  assign push = vld_p0 && core_s_axis_tready;
  assign head = tag_mem[rd_ptr];

  assign m0_axis_tdata      = core_m_axis_tdata;
  assign m1_axis_tdata      = core_m_axis_tdata;
  assign m0_axis_tvalid     = !empty && !head && core_m_axis_tvalid;
  assign m1_axis_tvalid     = !empty &&  head && core_m_axis_tvalid;
  assign core_m_axis_tready = !empty && (head ? m1_axis_tready : m0_axis_tready);
  assign pop                = core_m_axis_tready && core_m_axis_tvalid;

  assign in_flight = count;

  // Input FSM: capture a grant in IDLE, hold it on the core port through OFFER.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0   <= IDLE;
      vld_p0     <= 1'b0;
      gnt_p0     <= 1'b0;
      last_p0    <= 1'b1;
`ifdef MACGUFFIN_ARB_LOCK_EN
      lock_p0    <= 1'b0;
      lock_ch_p0 <= 1'b0;
`endif
    end else begin
      case (state_p0)
        IDLE: begin
          if (grant_now) begin
            state_p0   <= OFFER;
            vld_p0     <= 1'b1;
            gnt_p0     <= gnt_sel;
`ifdef MACGUFFIN_ARB_LOCK_EN
            lock_p0    <= !sel_last;
            lock_ch_p0 <= gnt_sel;
`endif
          end
        end
        OFFER: begin
          if (core_s_axis_tready) begin
            state_p0 <= IDLE;
            vld_p0   <= 1'b0;
            last_p0  <= gnt_p0;
          end
        end
        default: begin
          state_p0 <= IDLE;
          vld_p0   <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0: granted block's data, captured on the requester handshake.
  always_ff @(posedge clk) begin
    if (grant_now) data_p0 <= gnt_sel ? s1_axis_tdata : s0_axis_tdata;
  end

  // Tag storage: source channel of each block handed to the core.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_p0;
  end

  // Tag FIFO pointers and occupancy; simultaneous push and pop cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for core output arriving with no block outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           err_orphan <= 1'b0;
    else if (core_m_axis_tvalid && empty) err_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_macguffin_arbiter.sv
// Directed bench for macguffin_arbiter with a small 3-cycle core model that
// returns plaintext XOR 0xA. Build with MACGUFFIN_ARB_LOCK_EN for the lock case.
module tb_macguffin_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
  logic       s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
  logic       s0_axis_tready, s1_axis_tready;
`ifdef MACGUFFIN_ARB_LOCK_EN
  logic       s0_axis_tlast = 1'b0, s1_axis_tlast = 1'b0;
`endif
  logic [3:0] m0_axis_tdata, m1_axis_tdata;
  logic       m0_axis_tvalid, m1_axis_tvalid;
  logic       m0_axis_tready = 1'b1, m1_axis_tready = 1'b1;
  logic [3:0] core_s_axis_tdata;
  logic       core_s_axis_tvalid;
  logic       core_s_axis_tready;
  logic [3:0] core_m_axis_tdata;
  logic       core_m_axis_tvalid;
  logic       core_m_axis_tready;
  logic [2:0] in_flight;
  logic       err_orphan;

  // Core-side stimulus: either the model or manual drive.
  logic       model_en = 1'b0;
  logic       man_s_tready = 1'b0;
  logic       man_m_tvalid = 1'b0;
  logic [3:0] man_m_tdata = '0;
  logic       mdl_tvalid = 1'b0;
  logic [3:0] mdl_tdata = '0;

  assign core_s_axis_tready = model_en ? 1'b1 : man_s_tready;
  assign core_m_axis_tvalid = model_en ? mdl_tvalid : man_m_tvalid;
  assign core_m_axis_tdata  = model_en ? mdl_tdata  : man_m_tdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  macguffin_arbiter #(.DATA_W(4), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
`ifdef MACGUFFIN_ARB_LOCK_EN
    .s0_axis_tlast(s0_axis_tlast), .s1_axis_tlast(s1_axis_tlast),
`endif
    .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tready(m0_axis_tready),
    .m1_axis_tdata(m1_axis_tdata), .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tready(m1_axis_tready),
    .core_s_axis_tdata(core_s_axis_tdata), .core_s_axis_tvalid(core_s_axis_tvalid),
    .core_s_axis_tready(core_s_axis_tready),
    .core_m_axis_tdata(core_m_axis_tdata), .core_m_axis_tvalid(core_m_axis_tvalid),
    .core_m_axis_tready(core_m_axis_tready),
    .in_flight(in_flight), .err_orphan(err_orphan)
  );

  // Core model: fixed latency, XOR-0xA "cipher", honours output backpressure.
  typedef struct { logic [3:0] d; int due; } ent_t;
  ent_t mq[$];
  int   cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (model_en && core_s_axis_tvalid && core_s_axis_tready)
      mq.push_back('{d: core_s_axis_tdata ^ 4'hA, due: cyc + 3});
    if (model_en && mdl_tvalid && core_m_axis_tready && mq.size() > 0)
      mq.pop_front();
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      mdl_tvalid <= 1'b1;
      mdl_tdata  <= mq[0].d;
    end else begin
      mdl_tvalid <= 1'b0;
    end
  end

  // Handshake monitor.
  int s0_cnt = 0, s1_cnt = 0, m0_cnt = 0, m1_cnt = 0;
  logic [3:0] csq[$], m0q[$], m1q[$];
  always @(posedge clk) begin
    if (s0_axis_tvalid && s0_axis_tready) s0_cnt <= s0_cnt + 1;
    if (s1_axis_tvalid && s1_axis_tready) s1_cnt <= s1_cnt + 1;
    if (m0_axis_tvalid && m0_axis_tready) begin m0_cnt <= m0_cnt + 1; m0q.push_back(m0_axis_tdata); end
    if (m1_axis_tvalid && m1_axis_tready) begin m1_cnt <= m1_cnt + 1; m1q.push_back(m1_axis_tdata); end
    if (core_s_axis_tvalid && core_s_axis_tready) csq.push_back(core_s_axis_tdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Assert reset for two cycles; returns at a negedge with rst released.
  task automatic reset_dut();
    @(negedge clk);
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Offer one beat on a channel, wait for its ready, then drop valid.
  task automatic send_one(input int ch, input logic [3:0] d);
    int n = 0;
    if (ch == 0) begin s0_axis_tdata = d; s0_axis_tvalid = 1'b1; end
    else         begin s1_axis_tdata = d; s1_axis_tvalid = 1'b1; end
    #1;
    while (!(ch == 0 ? s0_axis_tready : s1_axis_tready) && n < 30) begin
      @(negedge clk); #1; n++;
    end
    chk("send_timeout", n < 30, 1);
    @(negedge clk);
    if (ch == 0) s0_axis_tvalid = 1'b0; else s1_axis_tvalid = 1'b0;
  endtask

  // Wait until nothing is pending anywhere.
  task automatic wait_drain();
    int n = 0;
    #1;
    while ((in_flight != 0 || core_s_axis_tvalid || core_m_axis_tvalid || mq.size() != 0) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("drain_timeout", n < 100, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, bm0, bm1, bc, cnt;

    // Reset mid-OFFER, then channel 0 wins first.
    reset_dut();
    model_en = 1'b0; man_s_tready = 1'b0;
    s1_axis_tdata = 4'h5; s1_axis_tvalid = 1'b1;
    #1 chk("lone_s1_ready", s1_axis_tready, 1);
    @(negedge clk);
    s0_axis_tdata = 4'h6; s0_axis_tvalid = 1'b1;
    #1;
    chk("offer_valid", core_s_axis_tvalid, 1);
    chk("offer_data", core_s_axis_tdata, 4'h5);
    chk("offer_s0_ready", s0_axis_tready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_core_valid", core_s_axis_tvalid, 0);
    chk("rst_s0_ready", s0_axis_tready, 0);
    chk("rst_s1_ready", s1_axis_tready, 0);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_core_m_ready", core_m_axis_tready, 0);
    chk("rst_m_valid", {m0_axis_tvalid, m1_axis_tvalid}, 0);
    chk("rst_err", err_orphan, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_s0_ready", s0_axis_tready, 1);
    chk("post_rst_s1_ready", s1_axis_tready, 0);
    @(posedge clk); #1;
    chk("post_rst_offer_data", core_s_axis_tdata, 4'h6);

    // Both channels valid continuously: strict alternation.
    reset_dut();
    model_en = 1'b1; m0_axis_tready = 1'b1; m1_axis_tready = 1'b1;
    bc = csq.size(); bm0 = m0q.size(); bm1 = m1q.size(); b0 = s0_cnt; b1 = s1_cnt;
    s0_axis_tdata = 4'h1; s1_axis_tdata = 4'h2;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1;
    repeat (24) @(negedge clk);
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    wait_drain();
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_core_in_%0d", i), csq[bc+i], (i % 2 == 0) ? 4'h1 : 4'h2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rr_m0_data_%0d", i), m0q[bm0+i], 4'hB);
      chk($sformatf("rr_m1_data_%0d", i), m1q[bm1+i], 4'h8);
    end
    chk("rr_m0_count", m0q.size() - bm0, s0_cnt - b0);
    chk("rr_m1_count", m1q.size() - bm1, s1_cnt - b1);

    // FIFO fills to 4 with output blocked, then drains to m1 only.
    reset_dut();
    model_en = 1'b1; m0_axis_tready = 1'b1; m1_axis_tready = 1'b0;
    b1 = s1_cnt; bm0 = m0_cnt; bm1 = m1q.size();
    s1_axis_tdata = 4'h3; s1_axis_tvalid = 1'b1;
    repeat (14) @(negedge clk);
    #1;
    chk("full_in_flight", in_flight, 4);
    chk("full_accepts", s1_cnt - b1, 4);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (s1_axis_tready) cnt++;
    end
    chk("full_s1_ready_low", cnt, 0);
    @(negedge clk);
    s1_axis_tvalid = 1'b0; m1_axis_tready = 1'b1;
    wait_drain();
    chk("full_m1_drained", m1q.size() - bm1, 4);
    chk("full_m1_data", m1q[m1q.size()-1], 4'h9);
    chk("full_m0_none", m0_cnt - bm0, 0);

    // Head stalled on m0 blocks the ch1 result queued behind it.
    reset_dut();
    model_en = 1'b1; m0_axis_tready = 1'b0; m1_axis_tready = 1'b1;
    bm0 = m0q.size(); bm1 = m1q.size();
    send_one(0, 4'h4);
    send_one(1, 4'h5);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (m1_axis_tvalid) cnt++;
    end
    chk("stall_m1_valid_low", cnt, 0);
    chk("stall_m0_valid", m0_axis_tvalid, 1);
    chk("stall_in_flight", in_flight, 2);
    @(negedge clk);
    m0_axis_tready = 1'b1;
    wait_drain();
    chk("stall_m0_data", m0q[bm0], 4'hE);
    chk("stall_m1_data", m1q[bm1], 4'hF);
    chk("stall_counts", {m0q.size() - bm0, m1q.size() - bm1}, {32'd1, 32'd1});

    // Orphan result: sticky error, ready stays low.
    reset_dut();
    model_en = 1'b0; man_s_tready = 1'b0;
    #1 chk("orphan_clear", err_orphan, 0);
    @(negedge clk);
    man_m_tdata = 4'h7; man_m_tvalid = 1'b1;
    #1;
    chk("orphan_core_ready", core_m_axis_tready, 0);
    chk("orphan_m_valid", {m0_axis_tvalid, m1_axis_tvalid}, 0);
    @(posedge clk); #1;
    chk("orphan_set", err_orphan, 1);
    @(negedge clk);
    man_m_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("orphan_sticky", err_orphan, 1);

`ifdef MACGUFFIN_ARB_LOCK_EN
    // Lock: ch1 waits for ch0's tlast beat even across ch0 valid gaps.
    reset_dut();
    model_en = 1'b1; m0_axis_tready = 1'b1; m1_axis_tready = 1'b1;
    b1 = s1_cnt; bc = csq.size();
    s1_axis_tdata = 4'h2; s1_axis_tlast = 1'b1; s1_axis_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s0_axis_tlast = (k == 2);
      send_one(0, 4'h1);
      if (k < 2) begin
        repeat (4) @(negedge clk);
        chk($sformatf("lock_hold_%0d", k), s1_cnt - b1, 0);
      end
    end
    chk("lock_before_last", s1_cnt - b1, 0);
    cnt = 0;
    while (s1_cnt == b1 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("lock_s1_granted", s1_cnt - b1, 1);
    @(negedge clk);
    s1_axis_tvalid = 1'b0;
    wait_drain();
    chk("lock_order_2", csq[bc+2], 4'h1);
    chk("lock_order_3", csq[bc+3], 4'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
